candy_payout: RTL and testbench

- Output-side actuator sequencer: consumes the dispense/change commands produced by the vending controller (candy, change_beg, change_obeg) and drives the physical candy motor and coin hoppers.
- One item is dispensed at a time. Each item is a timed pulse followed by a sensor-acknowledge handshake.
- Reports busy/done/fault to the controller and keeps a running count of candies delivered.

---
 rtl/candy_payout_pkg.sv | 39 +++
 rtl/candy_payout_if.sv | 28 ++
 rtl/candy_payout_timer.sv | 24 ++
 rtl/candy_payout.sv | 156 +++++++++++++++
 tb/tb_candy_payout.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/candy_payout_pkg.sv
// Shared types and defaults for the candy/coin payout sequencer and its benches.
package candy_payout_pkg;

  localparam int unsigned DefaultPulseLen   = 4;
  localparam int unsigned DefaultGapLen     = 2;
  localparam int unsigned DefaultAckTimeout = 16;
  localparam int unsigned DefaultCntW       = 8;
  localparam int unsigned TimerW            = 8;

  typedef enum logic [3:0] {
    StIdle,
    StLoad,
    StCandy,
    StBeg,
    StObeg,
    StWait,
    StGap,
    StFin,
    StFault
  } state_e;

  typedef enum logic [1:0] {
    ItemCandy,
    ItemBeg,
    ItemObeg
  } item_e;

  // First coin item still owed, or completion when none remain.
  function automatic state_e next_coin(logic [2:0] beg, logic obeg);
    if (beg != 3'd0) return StBeg;
    if (obeg) return StObeg;
    return StFin;
  endfunction

  function automatic logic is_pulse(state_e s);
    return (s == StCandy) || (s == StBeg) || (s == StObeg);
  endfunction

endpackage

// File: rtl/candy_payout_if.sv
// Controller/actuator-side signal bundle of the payout sequencer.
interface candy_payout_if #(
  parameter int unsigned CNT_W = 8
);
  logic             candy;
  logic [2:0]       change_beg;
  logic             change_obeg;
  logic             candy_ack;
  logic             coin_ack;
  logic             candy_motor;
  logic             beg_eject;
  logic             obeg_eject;
  logic             busy;
  logic             done;
  logic             fault;
  logic             overrun;
  logic [CNT_W-1:0] candy_count;

  modport master (
    output candy, change_beg, change_obeg, candy_ack, coin_ack,
    input  candy_motor, beg_eject, obeg_eject, busy, done, fault, overrun, candy_count
  );

  modport slave (
    input  candy, change_beg, change_obeg, candy_ack, coin_ack,
    output candy_motor, beg_eject, obeg_eject, busy, done, fault, overrun, candy_count
  );
endinterface

// File: rtl/candy_payout_timer.sv
// Loadable down-counter with zero flag; shared by pulse, gap and ack-timeout phases.
module candy_payout_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             zero_o
);
  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/candy_payout.sv
// Payout sequencer: serves one candy, then 100-unit coins, then a 50-unit coin, one timed
// actuator pulse per item, each confirmed by a sensor ack.
module candy_payout
  import candy_payout_pkg::*;
#(
  parameter int unsigned PULSE_LEN   = DefaultPulseLen,
  parameter int unsigned GAP_LEN     = DefaultGapLen,
  parameter int unsigned ACK_TIMEOUT = DefaultAckTimeout,
  parameter int unsigned CNT_W       = DefaultCntW
) (
  input logic           clk,
  input logic           reset,
  candy_payout_if.slave bus
);
  state_e             state_q, state_d;
  item_e              item_q, item_d;
  logic               candy_q, candy_d;
  logic [2:0]         beg_q, beg_d;
  logic               obeg_q, obeg_d;
  logic               ack_seen_q, ack_seen_d;
  logic               overrun_q, overrun_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               motor_q, beg_ej_q, obeg_ej_q, busy_q, done_q, fault_q;
  logic               tmr_load, tmr_zero;
  logic [TimerW-1:0]  tmr_val;
  logic               req, ack, sampling;

  assign req      = bus.candy | (bus.change_beg != 3'd0) | bus.change_obeg;
  assign ack      = (item_q == ItemCandy) ? bus.candy_ack : bus.coin_ack;
  assign sampling = is_pulse(state_q) || (state_q == StWait);

  candy_payout_timer #(
    .Width(TimerW)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .zero_o    (tmr_zero)
  );

  always_comb begin
    state_d    = state_q;
    item_d     = item_q;
    candy_d    = candy_q;
    beg_d      = beg_q;
    obeg_d     = obeg_q;
    ack_seen_d = ack_seen_q;
    overrun_d  = overrun_q;
    count_d    = count_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;

    if (state_q != StIdle && req) overrun_d = 1'b1;

    // Each item's ack is accepted once, whether it lands in the pulse or in WAIT.
    if (sampling && ack && !ack_seen_q) begin
      ack_seen_d = 1'b1;
      if (item_q == ItemCandy) count_d = count_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (req) begin
          candy_d = bus.candy;
          beg_d   = bus.change_beg;
          obeg_d  = bus.change_obeg;
          state_d = StLoad;
        end
      end
      StLoad: state_d = candy_q ? StCandy : next_coin(beg_q, obeg_q);
      StCandy, StBeg, StObeg: begin
        if (tmr_zero) begin
          state_d  = StWait;
          tmr_load = 1'b1;
          tmr_val  = TimerW'(ACK_TIMEOUT - 1);
        end
      end
      StWait: begin
        if (ack_seen_q || ack) begin
          unique case (item_q)
            ItemCandy: state_d = next_coin(beg_q, obeg_q);
            ItemBeg: begin
              state_d  = StGap;
              tmr_load = 1'b1;
              tmr_val  = TimerW'(GAP_LEN - 1);
            end
            default: state_d = StFin;
          endcase
        end else if (tmr_zero) begin
          state_d = StFault;
        end
      end
      StGap: begin
        if (tmr_zero) begin
          beg_d   = beg_q - 3'd1;
          state_d = next_coin(beg_d, obeg_q);
        end
      end
      StFin:   state_d = StIdle;
      StFault: state_d = StFault;
      default: state_d = StIdle;
    endcase

    if (is_pulse(state_d) && !is_pulse(state_q)) begin
      tmr_load   = 1'b1;
      tmr_val    = TimerW'(PULSE_LEN - 1);
      ack_seen_d = 1'b0;
      item_d     = (state_d == StCandy) ? ItemCandy : (state_d == StBeg) ? ItemBeg : ItemObeg;
    end
  end

  // Outputs are decoded from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      item_q     <= ItemCandy;
      candy_q    <= 1'b0;
      beg_q      <= '0;
      obeg_q     <= 1'b0;
      ack_seen_q <= 1'b0;
      overrun_q  <= 1'b0;
      count_q    <= '0;
      motor_q    <= 1'b0;
      beg_ej_q   <= 1'b0;
      obeg_ej_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      item_q     <= item_d;
      candy_q    <= candy_d;
      beg_q      <= beg_d;
      obeg_q     <= obeg_d;
      ack_seen_q <= ack_seen_d;
      overrun_q  <= overrun_d;
      count_q    <= count_d;
      motor_q    <= (state_d == StCandy);
      beg_ej_q   <= (state_d == StBeg);
      obeg_ej_q  <= (state_d == StObeg);
      busy_q     <= (state_d != StIdle) && (state_d != StFin);
      done_q     <= (state_d == StFin);
      fault_q    <= (state_d == StFault);
    end
  end

  assign bus.candy_motor = motor_q;
  assign bus.beg_eject   = beg_ej_q;
  assign bus.obeg_eject  = obeg_ej_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.fault       = fault_q;
  assign bus.overrun     = overrun_q;
  assign bus.candy_count = count_q;
endmodule

// File: tb/tb_candy_payout.sv
// Scoreboard bench for candy_payout: expected per-sequence results are queued at request
// time and compared when done pulses; a monitor checks pulse widths, gaps and exclusivity.
module tb_candy_payout;
  import candy_payout_pkg::*;

  localparam int unsigned PulseLen   = DefaultPulseLen;
  localparam int unsigned GapLen     = DefaultGapLen;
  localparam int unsigned AckTimeout = DefaultAckTimeout;
  localparam int unsigned CntW       = 8;

  typedef struct {
    int n_candy;
    int n_beg;
    int n_obeg;
    int count;
    int first_cyc;
    int done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb_q[$];
  logic [CntW-1:0] model_count;
  logic ack_mode;
  logic stray_ack;
  logic resp_candy_ack, resp_coin_ack;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  candy_payout_if #(.CNT_W(CntW)) bus ();

  candy_payout #(
    .PULSE_LEN  (PulseLen),
    .GAP_LEN    (GapLen),
    .ACK_TIMEOUT(AckTimeout),
    .CNT_W      (CntW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  assign bus.candy_ack = resp_candy_ack | stray_ack;
  assign bus.coin_ack  = resp_coin_ack;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, $signed(got), $signed(exp), cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sensor model: candy ack on the 2nd pulse cycle, coin ack in the cycle after a coin pulse.
  initial begin
    int  run = 0;
    logic prev_coin = 1'b0;
    resp_candy_ack = 1'b0;
    resp_coin_ack  = 1'b0;
    forever begin
      @(negedge clk);
      resp_candy_ack = 1'b0;
      resp_coin_ack  = 1'b0;
      run = bus.candy_motor ? run + 1 : 0;
      if (ack_mode && bus.candy_motor && run == 2) resp_candy_ack = 1'b1;
      if (ack_mode && prev_coin && !(bus.beg_eject || bus.obeg_eject)) resp_coin_ack = 1'b1;
      prev_coin = bus.beg_eject || bus.obeg_eject;
    end
  end

  // Output monitor and scoreboard consumer.
  initial begin
    int m_candy = 0, m_beg = 0, m_obeg = 0, run_len = 0, gap_len = 0, first_cyc = -1;
    logic coin_seen = 1'b0;
    logic [2:0] act, prev_act = 3'b000;
    exp_t e;
    forever begin
      @(negedge clk);
      act = {bus.candy_motor, bus.beg_eject, bus.obeg_eject};
      if (reset) begin
        m_candy = 0; m_beg = 0; m_obeg = 0; run_len = 0; gap_len = 0; first_cyc = -1;
        coin_seen = 1'b0;
        prev_act = 3'b000;
      end else begin
        check_eq("act_onehot", 64'($countones(act) <= 1), 64'd1);
        if (act != 3'b000) begin
          if (prev_act == 3'b000) begin
            if (first_cyc < 0) first_cyc = cyc;
            if (!act[2] && coin_seen) check_eq("coin_gap", gap_len, GapLen + 1);
            run_len = 0;
          end
          run_len++;
        end else if (prev_act != 3'b000) begin
          check_eq("pulse_width", run_len, PulseLen);
          if (prev_act[2]) m_candy++;
          else if (prev_act[1]) m_beg++;
          else m_obeg++;
          if (!prev_act[2]) begin
            coin_seen = 1'b1;
            gap_len = 0;
          end
        end
        if (act == 3'b000 && coin_seen) gap_len++;
        if (bus.done) begin
          if (sb_q.size() == 0) begin
            check_eq("sb_nonempty", sb_q.size(), 1);
          end else begin
            e = sb_q.pop_front();
            check_eq("n_candy", m_candy, e.n_candy);
            check_eq("n_beg", m_beg, e.n_beg);
            check_eq("n_obeg", m_obeg, e.n_obeg);
            check_eq("candy_count", bus.candy_count, e.count);
            check_eq("first_act_cyc", first_cyc, e.first_cyc);
            check_eq("done_cyc", cyc, e.done_cyc);
            check_eq("busy_at_done", bus.busy, 0);
          end
          m_candy = 0; m_beg = 0; m_obeg = 0; first_cyc = -1;
          coin_seen = 1'b0;
        end
        prev_act = act;
      end
    end
  end

  task automatic push_exp(input int c, input int b, input int o);
    exp_t e;
    model_count = model_count + CntW'(c);
    e.n_candy   = c;
    e.n_beg     = b;
    e.n_obeg    = o;
    e.count     = int'(model_count);
    e.first_cyc = cyc + 2;
    e.done_cyc  = cyc + 2 + c * (PulseLen + 1) + b * (PulseLen + 1 + GapLen) + o * (PulseLen + 1);
    sb_q.push_back(e);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!bus.done && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!bus.done) check_eq("done_seen", bus.done, 1);
    tick(1);
  endtask

  task automatic run_seq(input int c, input int b, input int o);
    bus.candy       = c[0];
    bus.change_beg  = b[2:0];
    bus.change_obeg = o[0];
    push_exp(c, b, o);
    tick(1);
    bus.candy       = 1'b0;
    bus.change_beg  = 3'd0;
    bus.change_obeg = 1'b0;
    wait_done(200);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    sb_q.delete();
    model_count = '0;
  endtask

  initial begin
    int c0;
    int k;
    bus.candy       = 1'b0;
    bus.change_beg  = 3'd0;
    bus.change_obeg = 1'b0;
    stray_ack       = 1'b0;
    ack_mode        = 1'b1;
    model_count     = '0;
    reset           = 1'b1;
    tick(3);
    check_eq("rst_candy_motor", bus.candy_motor, 0);
    check_eq("rst_beg_eject", bus.beg_eject, 0);
    check_eq("rst_obeg_eject", bus.obeg_eject, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_fault", bus.fault, 0);
    check_eq("rst_overrun", bus.overrun, 0);
    check_eq("rst_count", bus.candy_count, 0);
    reset = 1'b0;
    tick(2);

    // Stray acks while idle change nothing.
    stray_ack = 1'b1;
    tick(3);
    stray_ack = 1'b0;
    tick(1);
    check_eq("stray_count", bus.candy_count, 0);
    check_eq("stray_busy", bus.busy, 0);

    run_seq(1, 0, 0);
    run_seq(0, 3, 1);
    run_seq(1, 7, 1);
    run_seq(0, 0, 1);
    run_seq(1, 1, 0);
    check_eq("no_overrun_yet", bus.overrun, 0);

    // Overrun: candy request mid-sequence is dropped.
    bus.change_beg = 3'd2;
    push_exp(0, 2, 0);
    tick(1);
    bus.change_beg = 3'd0;
    tick(4);
    bus.candy = 1'b1;
    tick(1);
    bus.candy = 1'b0;
    wait_done(200);
    check_eq("overrun_set", bus.overrun, 1);

    // Timeout: no candy ack ever arrives.
    do_reset();
    check_eq("overrun_cleared", bus.overrun, 0);
    ack_mode = 1'b0;
    c0 = cyc;
    bus.candy = 1'b1;
    tick(1);
    bus.candy = 1'b0;
    k = 0;
    while (!bus.fault && k < 100) begin
      tick(1);
      k++;
    end
    check_eq("fault_cyc", cyc, c0 + 2 + PulseLen + AckTimeout);
    check_eq("fault_busy", bus.busy, 1);
    check_eq("fault_acts", {bus.candy_motor, bus.beg_eject, bus.obeg_eject}, 0);
    check_eq("fault_count", bus.candy_count, 0);
    tick(5);
    check_eq("fault_sticky", bus.fault, 1);
    check_eq("fault_busy_held", bus.busy, 1);
    ack_mode = 1'b1;

    // Reset during a coin pulse aborts at once.
    do_reset();
    bus.change_beg = 3'd1;
    tick(1);
    bus.change_beg = 3'd0;
    k = 0;
    while (!bus.beg_eject && k < 20) begin
      tick(1);
      k++;
    end
    check_eq("beg_pulse_seen", bus.beg_eject, 1);
    tick(1);
    reset = 1'b1;
    tick(1);
    check_eq("abort_beg_eject", bus.beg_eject, 0);
    check_eq("abort_busy", bus.busy, 0);
    check_eq("abort_fault", bus.fault, 0);
    reset = 1'b0;
    sb_q.delete();
    model_count = '0;
    run_seq(1, 0, 0);

    // Counter wraps after 2^CNT_W deliveries.
    do_reset();
    repeat (256) run_seq(1, 0, 0);
    check_eq("count_wrap", bus.candy_count, 0);
    check_eq("sb_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
